uart_rx_os: RTL and testbench

UART_RX_OS -- requirements
Module: uart_rx_os

---
 rtl/uart_rx_os.sv | 113 +++++++++++
 tb/tb_uart_rx_os.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os.sv
// uart_rx_os: 8N1 UART receiver that samples the line at 16x the bit rate.
//   clk, rst_n : system clock (rising edge) and async active-low reset
//   rs232_rx   : raw serial line, idle high, LSB first
//   rx_data    : last correctly framed byte, held until the next good frame
//   rx_valid   : one-clk pulse when rx_data updates
//   rx_int     : high while a frame is in progress (START/DATA/STOP)
//   frame_err  : one-clk pulse when the stop bit is sampled low
module uart_rx_os #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rs232_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_int,
  output logic       frame_err
);
  localparam int DIV = CLK_HZ / (BAUD * 16);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;

  logic          sync1, s_rx, s_rx_d;
  logic [DW-1:0] div_cnt;
  logic [3:0]    s_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          smp7, smp8;
  logic          tick, decide, bit_end, maj, fall;
  logic          shift_en, load_en, ferr_en;

  assign tick    = (state != IDLE) && (div_cnt == DW'(DIV - 1));
  assign decide  = tick && (s_cnt == 4'd9);
  assign bit_end = tick && (s_cnt == 4'd15);
  // third sample is the live s_rx at the s_cnt==9 tick
  assign maj     = (smp7 & smp8) | (smp7 & s_rx) | (smp8 & s_rx);
  assign fall    = s_rx_d & ~s_rx;
  assign rx_int  = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n  = state;
    shift_en = 1'b0;
    load_en  = 1'b0;
    ferr_en  = 1'b0;
    case (state)
      IDLE:  if (fall) state_n = START;
      START: begin
        if (decide && maj) state_n = IDLE;   // start bit did not hold: glitch
        else if (bit_end)  state_n = DATA;
      end
      DATA: begin
        if (decide) shift_en = 1'b1;
        if (bit_end && bit_idx == 3'd7) state_n = STOP;
      end
      STOP: begin
        // leave at mid stop bit so the next start edge is never missed
        if (decide) begin
          state_n = IDLE;
          if (maj) load_en = 1'b1;
          else     ferr_en = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= 1'b1;
      s_rx      <= 1'b1;
      s_rx_d    <= 1'b1;
      div_cnt   <= '0;
      s_cnt     <= '0;
      smp7      <= 1'b0;
      smp8      <= 1'b0;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sync1  <= rs232_rx;
      s_rx   <= sync1;
      s_rx_d <= s_rx;

      // held at 0 in IDLE so the first tick lands DIV clks after START entry
      if (state == IDLE || tick) div_cnt <= '0;
      else                       div_cnt <= div_cnt + DW'(1);

      if (state == IDLE) s_cnt <= '0;
      else if (tick)     s_cnt <= s_cnt + 4'd1;

      if (tick && s_cnt == 4'd7) smp7 <= s_rx;
      if (tick && s_cnt == 4'd8) smp8 <= s_rx;

      if (state != DATA) bit_idx <= '0;
      else if (bit_end)  bit_idx <= bit_idx + 3'd1;

      if (shift_en) shreg   <= {maj, shreg[7:1]};
      if (load_en)  rx_data <= shreg;
      rx_valid  <= load_en;
      frame_err <= ferr_en;
    end
  end
endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: randomized/directed bench for uart_rx_os at a scaled bit rate
// (DIV=10, 160 clk/bit) so every scenario fits in a short run.
module tb_uart_rx_os;
  localparam int CLK_HZ = 1600000;
  localparam int BAUD   = 10000;
  localparam int DIV    = CLK_HZ / (BAUD * 16);
  localparam int BIT    = 16 * DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_line = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, rx_int, frame_err;

  uart_rx_os #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk(clk), .rst_n(rst_n), .rs232_rx(rx_line),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_int(rx_int), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int errs = 0, checks = 0;
  int cyc = 0;
  logic [7:0] got_q[$];
  int vcyc_q[$];
  int ferr_cnt = 0, both_cnt = 0, wide_cnt = 0, sync_bad = 0;
  int int_rise_cyc = 0, int_fall_cyc = 0;
  logic prev_int = 1'b0, prev_valid = 1'b0;
  logic [7:0] last_good = 8'h00;
  int t0 = 0;

  // passive monitor, sampled away from the active edge
  always @(negedge clk) begin
    cyc <= cyc + 1;
    prev_int   <= rx_int;
    prev_valid <= rx_valid;
    if (rx_valid) begin
      got_q.push_back(rx_data);
      vcyc_q.push_back(cyc);
    end
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if (rx_valid && frame_err) both_cnt <= both_cnt + 1;
    if (rx_valid && prev_valid) wide_cnt <= wide_cnt + 1;
    if ((rx_valid || frame_err) && (rx_int !== 1'b0 || prev_int !== 1'b1))
      sync_bad <= sync_bad + 1;
    if (rx_int && !prev_int) int_rise_cyc <= cyc;
    if (!rx_int && prev_int) int_fall_cyc <= cyc;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    t0 = cyc;
    rx_line = 1'b0;
    wait_clks(BIT);
    for (int i = 0; i < 8; i++) begin
      rx_line = d[i];
      wait_clks(BIT);
    end
    rx_line = stop;
    wait_clks(BIT);
  endtask

  task automatic clear_mon;
    got_q.delete();
    vcyc_q.delete();
  endtask

  task automatic test_reset;
    #1;
    checks++; if (rx_data !== 8'h00) begin errs++; $display("FAIL reset_data: got %h want 00", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
    checks++; if (rx_int !== 1'b0) begin errs++; $display("FAIL reset_int: got %b want 0", rx_int); end
    checks++; if (frame_err !== 1'b0) begin errs++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
    rst_n = 1'b1;
    wait_clks(BIT);
  endtask

  task automatic test_single;
    int lat, ferr0;
    clear_mon();
    ferr0 = ferr_cnt;
    send_frame(8'h55, 1'b1);
    rx_line = 1'b1;
    wait_clks(BIT);
    last_good = 8'h55;
    checks++; if (got_q.size() != 1) begin errs++; $display("FAIL single_count: got %0d want 1", got_q.size()); end
    if (got_q.size() >= 1) begin
      checks++; if (got_q[0] !== 8'h55) begin errs++; $display("FAIL single_data: got %h want 55", got_q[0]); end
      // pulse is expected about 9.56 bit times after the start edge
      lat = vcyc_q[0] - t0 - (BIT * 153) / 16;
      if (lat < 0) lat = -lat;
      checks++; if (lat > 2 * DIV + 4) begin errs++; $display("FAIL single_latency: got %0d want %0d", vcyc_q[0] - t0, (BIT * 153) / 16); end
      checks++; if (int_fall_cyc != vcyc_q[0]) begin errs++; $display("FAIL single_int_fall: got %0d want %0d", int_fall_cyc, vcyc_q[0]); end
    end
    checks++; if (int_rise_cyc - t0 > 4 || int_rise_cyc < t0) begin errs++; $display("FAIL single_int_rise: got %0d want near %0d", int_rise_cyc, t0); end
    checks++; if (ferr_cnt != ferr0) begin errs++; $display("FAIL single_ferr: got %0d want %0d", ferr_cnt - ferr0, 0); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_b[3];
    exp_b[0] = 8'hA3; exp_b[1] = 8'h0F; exp_b[2] = 8'hFF;
    clear_mon();
    for (int i = 0; i < 3; i++) send_frame(exp_b[i], 1'b1);
    rx_line = 1'b1;
    wait_clks(BIT);
    last_good = 8'hFF;
    checks++; if (got_q.size() != 3) begin errs++; $display("FAIL b2b_count: got %0d want 3", got_q.size()); end
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_b[i]) begin errs++; $display("FAIL b2b_data%0d: got %h want %h", i, got_q[i], exp_b[i]); end
    end
  endtask

  task automatic test_random;
    logic [7:0] exp_q[$];
    logic [7:0] d;
    clear_mon();
    for (int k = 0; k < 6; k++) begin
      d = 8'($urandom_range(0, 255));
      exp_q.push_back(d);
      send_frame(d, 1'b1);
      rx_line = 1'b1;
      wait_clks($urandom_range(0, BIT));
    end
    wait_clks(2 * BIT);
    last_good = exp_q[5];
    checks++; if (got_q.size() != 6) begin errs++; $display("FAIL rand_count: got %0d want 6", got_q.size()); end
    for (int i = 0; i < 6 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errs++; $display("FAIL rand_data%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_glitch;
    int ferr0;
    clear_mon();
    ferr0 = ferr_cnt;
    rx_line = 1'b0;
    wait_clks(6 * DIV);
    checks++; if (rx_int !== 1'b1) begin errs++; $display("FAIL glitch_int_high: got %b want 1", rx_int); end
    rx_line = 1'b1;
    wait_clks(6 * DIV);
    // abort must happen at the first majority decision, well before one bit
    checks++; if (rx_int !== 1'b0) begin errs++; $display("FAIL glitch_int_low: got %b want 0", rx_int); end
    wait_clks(BIT);
    checks++; if (got_q.size() != 0) begin errs++; $display("FAIL glitch_valid: got %0d want 0", got_q.size()); end
    checks++; if (ferr_cnt != ferr0) begin errs++; $display("FAIL glitch_ferr: got %0d want 0", ferr_cnt - ferr0); end
    checks++; if (rx_data !== last_good) begin errs++; $display("FAIL glitch_data: got %h want %h", rx_data, last_good); end
  endtask

  task automatic test_frame_err;
    int ferr0;
    clear_mon();
    ferr0 = ferr_cnt;
    send_frame(8'h3C, 1'b0);
    wait_clks(2 * BIT);      // line stays low: no retrigger allowed
    checks++; if (ferr_cnt - ferr0 != 1) begin errs++; $display("FAIL ferr_count: got %0d want 1", ferr_cnt - ferr0); end
    checks++; if (got_q.size() != 0) begin errs++; $display("FAIL ferr_valid: got %0d want 0", got_q.size()); end
    checks++; if (rx_data !== last_good) begin errs++; $display("FAIL ferr_data: got %h want %h", rx_data, last_good); end
    checks++; if (rx_int !== 1'b0) begin errs++; $display("FAIL ferr_no_retrigger: got %b want 0", rx_int); end
    rx_line = 1'b1;
    wait_clks(BIT);
    send_frame(8'h5A, 1'b1);
    rx_line = 1'b1;
    wait_clks(BIT);
    last_good = 8'h5A;
    checks++; if (got_q.size() != 1) begin errs++; $display("FAIL ferr_recover_count: got %0d want 1", got_q.size()); end
    if (got_q.size() >= 1) begin
      checks++; if (got_q[0] !== 8'h5A) begin errs++; $display("FAIL ferr_recover_data: got %h want 5a", got_q[0]); end
    end
  endtask

  task automatic test_spike;
    clear_mon();
    rx_line = 1'b0;
    wait_clks(3 * BIT);               // start, bit0, bit1
    wait_clks(8 * DIV + DIV / 2);     // bit2 up to just before its middle sample
    rx_line = 1'b1;
    wait_clks(DIV);                   // one-sample spike
    rx_line = 1'b0;
    wait_clks(BIT - 9 * DIV - DIV / 2);
    wait_clks(5 * BIT);               // bits 3..7
    rx_line = 1'b1;
    wait_clks(2 * BIT);
    last_good = 8'h00;
    checks++; if (got_q.size() != 1) begin errs++; $display("FAIL spike_count: got %0d want 1", got_q.size()); end
    if (got_q.size() >= 1) begin
      checks++; if (got_q[0] !== 8'h00) begin errs++; $display("FAIL spike_data: got %h want 00", got_q[0]); end
    end
  endtask

  task automatic test_reset_mid;
    int ferr0;
    logic [7:0] d;
    d = 8'($urandom_range(0, 255));
    clear_mon();
    ferr0 = ferr_cnt;
    rx_line = 1'b0;
    wait_clks(BIT);
    for (int i = 0; i < 4; i++) begin
      rx_line = d[i];
      wait_clks(BIT);
    end
    rx_line = d[4];
    wait_clks(BIT / 2);
    rst_n = 1'b0;
    #1;
    checks++; if (rx_int !== 1'b0) begin errs++; $display("FAIL rstmid_int: got %b want 0", rx_int); end
    checks++; if (rx_data !== 8'h00) begin errs++; $display("FAIL rstmid_data: got %h want 00", rx_data); end
    checks++; if (rx_valid !== 1'b0 || frame_err !== 1'b0) begin errs++; $display("FAIL rstmid_pulses: got %b%b want 00", rx_valid, frame_err); end
    wait_clks(4);
    rx_line = 1'b1;
    wait_clks(4);
    rst_n = 1'b1;
    wait_clks(BIT);
    last_good = 8'h00;
    checks++; if (got_q.size() != 0 || ferr_cnt != ferr0) begin errs++; $display("FAIL rstmid_abandon: got %0d/%0d want 0/0", got_q.size(), ferr_cnt - ferr0); end
    send_frame(8'h81, 1'b1);
    rx_line = 1'b1;
    wait_clks(BIT);
    last_good = 8'h81;
    checks++; if (got_q.size() != 1) begin errs++; $display("FAIL rstmid_count: got %0d want 1", got_q.size()); end
    if (got_q.size() >= 1) begin
      checks++; if (got_q[0] !== 8'h81) begin errs++; $display("FAIL rstmid_rx: got %h want 81", got_q[0]); end
    end
  endtask

  task automatic test_protocol;
    checks++; if (both_cnt != 0) begin errs++; $display("FAIL proto_both: got %0d want 0", both_cnt); end
    checks++; if (wide_cnt != 0) begin errs++; $display("FAIL proto_width: got %0d want 0", wide_cnt); end
    checks++; if (sync_bad != 0) begin errs++; $display("FAIL proto_int_edge: got %0d want 0", sync_bad); end
    checks++; if (rx_data !== last_good) begin errs++; $display("FAIL proto_hold: got %h want %h", rx_data, last_good); end
  endtask

  initial begin
    wait_clks(3);
    test_reset();
    test_single();
    test_back_to_back();
    test_random();
    test_glitch();
    test_frame_err();
    test_spike();
    test_reset_mid();
    test_protocol();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
